// File: rtl/register_file.sv
// Bank of DEPTH independent WIDTH-bit registers, all contents presented in parallel on data_out.
// Optional macro REGISTER_FILE_R0_ZERO_EN hardwires R0 to zero and ignores en[0].
module register_file #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [DEPTH-1:0]         en,
  output logic [WIDTH*DEPTH-1:0]   data_out
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_d, regs_q;

  // A register only ever takes data_in when its enable is a clean 1; otherwise it keeps its value.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (en[i] == 1'b1) begin
        regs_d[i] = data_in;
      end
    end
`ifdef REGISTER_FILE_R0_ZERO_EN
    regs_d[0] = '0;
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // R0 lands in the LSBs; no path from data_in or en reaches the output.
  assign data_out = regs_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table-driven vectors with a scoreboard queue,
// plus hand-written reset sequences.
module tb_register_file;

  localparam int unsigned W = 16;
  localparam int unsigned D = 16;

`ifdef REGISTER_FILE_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [W-1:0]     data_in;
  logic [D-1:0]     en;
  logic [W*D-1:0]   data_out;

  register_file #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .en      (en),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] en;
    logic [W-1:0] din;
    int           chk_idx;
    logic [W-1:0] chk_val;
  } vec_t;

  vec_t                   vecs [12];
  logic [D-1:0][W-1:0]    m, m_next;
  logic [W*D-1:0]         sb_q [$];
  logic [W*D-1:0]         exp_v;
  logic [W*D-1:0]         ones_v;
  int                     n_vec = 0;
  int                     n_err = 0;

  task automatic check(input string name, input logic [W*D-1:0] act, input logic [W*D-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model of one clock edge.
  function automatic logic [D-1:0][W-1:0] model_step(input logic [D-1:0][W-1:0] cur,
                                                     input logic [D-1:0] e,
                                                     input logic [W-1:0] d);
    logic [D-1:0][W-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < D; i++) begin
      if (e[i]) nxt[i] = d;
    end
    if (R0Zero) nxt[0] = '0;
    return nxt;
  endfunction

  initial begin
    vecs[0]  = '{16'hFFFF, 16'h0000, 15, 16'h0000};
    vecs[1]  = '{16'h0008, 16'h0123, 3,  16'h0123};
    vecs[2]  = '{16'h0080, 16'h4545, 7,  16'h4545};
    vecs[3]  = '{16'h8000, 16'hAEAE, 15, 16'hAEAE};
    vecs[4]  = '{16'h0000, 16'hFFFF, 3,  16'h0123};
    vecs[5]  = '{16'h0000, 16'h0000, 7,  16'h4545};
    vecs[6]  = '{16'h0000, 16'h5555, 15, 16'hAEAE};
    vecs[7]  = '{16'h0000, 16'hAAAA, 3,  16'h0123};
    vecs[8]  = '{16'h0000, 16'h1234, 7,  16'h4545};
    vecs[9]  = '{16'h0011, 16'h5A5A, 4,  16'h5A5A};
    vecs[10] = '{16'h0001, 16'h1111, 0,  R0Zero ? 16'h0000 : 16'h1111};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 9,  16'hFFFF};

    ones_v = '1;
    if (R0Zero) ones_v[W-1:0] = '0;

    // Writes asserted during reset must be ignored.
    rst = 1'b1; en = '1; data_in = 16'hFFFF;
    #1 check("reset_state", data_out, '0);
    repeat (2) @(posedge clk);
    #1 check("write_in_reset", data_out, '0);
    @(negedge clk);
    en = '0;
    rst = 1'b0;
    m = '0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en = vecs[i].en;
      data_in = vecs[i].din;
      m_next = model_step(m, vecs[i].en, vecs[i].din);
      sb_q.push_back(m_next);
      #1 check($sformatf("no_bypass[%0d]", i), data_out, m);
      @(posedge clk);
      #1;
      exp_v = sb_q.pop_front();
      check($sformatf("vec[%0d]", i), data_out, exp_v);
      check($sformatf("reg[%0d].R%0d", i, vecs[i].chk_idx),
            {{(W*D-W){1'b0}}, data_out[W*vecs[i].chk_idx +: W]},
            {{(W*D-W){1'b0}}, vecs[i].chk_val});
      m = m_next;
    end

    // Mid-cycle reset with arbitrary contents and an all-ones write pending.
    @(negedge clk);
    en = 16'h0ABC; data_in = 16'h3C3C;
    @(posedge clk);
    #1 check("pre_reset_contents", data_out, model_step(m, 16'h0ABC, 16'h3C3C));
    en = '1; data_in = 16'hFFFF;
    #2 rst = 1'b1;
    #1 check("async_reset", data_out, '0);
    @(posedge clk);
    #1 check("reset_hold_1", data_out, '0);
    @(posedge clk);
    #1 check("reset_hold_2", data_out, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("before_first_edge", data_out, '0);
    @(posedge clk);
    #1 check("first_write", data_out, ones_v);

    en = '0;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each register.
REQ-002 Parameter DEPTH, default 16: number of registers; the enable bus has one bit per register.
REQ-003 Port clk, input, 1: the single clock; all register updates occur on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port data_in, input, WIDTH: write data, shared by all registers.
REQ-006 Port en, input, DEPTH: per-register write enable; bit i selects register i.
REQ-007 Port data_out, output, WIDTH*DEPTH: all register contents, presented in parallel.
REQ-008 Port order SHALL be clk, rst, data_in, en, data_out.

Function
REQ-009 The block SHALL hold DEPTH independent registers R0..R(DEPTH-1), each WIDTH bits wide.
REQ-010 On each rising clk edge with rst low, every register i with en[i]=1 SHALL load data_in.
REQ-011 On each rising clk edge with rst low, every register i with en[i]=0 SHALL hold its value.
REQ-012 en is not required to be one-hot; any number of bits may be set in the same cycle, and every selected register SHALL load the same data_in; en=all-ones writes every register.
REQ-013 en=0 SHALL leave all registers unchanged.
REQ-014 data_out[WIDTH*i+WIDTH-1 : WIDTH*i] SHALL equal register i, so R0 occupies the LSBs and R(DEPTH-1) the MSBs.
REQ-015 data_out SHALL be driven directly from the register outputs, with no combinational path from data_in or en.
REQ-016 Write latency SHALL be one edge: a value written on edge N SHALL be visible on data_out immediately after edge N.
REQ-017 There SHALL be no read-during-write bypass; before the edge, data_out shows the old value.
REQ-018 X or Z on en bits that are 0 SHALL NOT corrupt the unselected registers.

Reset
REQ-019 While rst=1, all registers SHALL be 0, and data_out SHALL be all-zero, independent of clk.
REQ-020 Assertion of rst SHALL clear the registers immediately, without waiting for a clock edge, including in the middle of a write cycle.
REQ-021 While rst=1, writes SHALL be ignored.
REQ-022 The first write SHALL occur on the first rising clk edge after rst has deasserted.

Configuration
REQ-023 Macro REGISTER_FILE_R0_ZERO_EN:
- When defined, R0 SHALL be hardwired to 0.
- When defined, en[0] SHALL be ignored.
- When defined, data_out[WIDTH-1:0] SHALL be constant 0.
- When undefined, R0 SHALL behave like every other register.

Verification
REQ-024 Reset: assert rst with arbitrary contents present -> data_out = 0 immediately, before any clk edge.
REQ-025 Broadcast: en=16'hFFFF, data_in=16'h0000 for one edge -> all 256 bits of data_out = 0.
REQ-026 Single writes, each for one edge:
- en[3]=1, data_in=16'h0123 -> data_out[63:48]=16'h0123.
- then en[7]=1, data_in=16'h4545 -> data_out[127:112]=16'h4545, and R3 still holds 16'h0123.
- then en[15]=1, data_in=16'hAEAE -> data_out[255:240]=16'hAEAE, and R3 and R7 are retained.
REQ-027 Hold: en=0 with data_in toggling over 5 edges -> data_out unchanged.
REQ-028 Multi-bit enable: en=16'h0011, data_in=16'h5A5A -> R0 and R4 = 16'h5A5A, others unchanged; with REGISTER_FILE_R0_ZERO_EN defined, R0 = 0 instead.
REQ-029 Mid-cycle reset: assert rst between edges while en=16'hFFFF, data_in=16'hFFFF -> data_out = 0 at once and stays 0 until the first edge after rst falls.
